// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Program memory loader and in-order instruction fetch/issue FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        le_pm,
    input  logic        load_wr,
    input  logic [27:0] load_instr,
    input  logic        exec_done,
    input  logic [4:0]  pc_next,
    output logic [27:0] instruction,
    output logic        instr_valid,
    output logic [4:0]  fetch_pc,
    output logic [5:0]  prog_len,
    output logic        load_full,
    output logic        halted
);

    localparam int       DEPTH     = 32;
    localparam logic [3:0] MAX_OPCODE = 4'd6;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [27:0] r_mem [DEPTH];
    logic [27:0] r_instruction;
    logic        r_instr_valid;
    logic [4:0]  r_fetch_pc;
    logic [4:0]  r_load_ptr;
    logic [5:0]  r_prog_len;
    logic        r_load_full;
    logic        r_halted;

    logic [27:0] w_rd_word;
    logic        w_past_end;
    logic        w_bad_op;
    logic        w_mem_we;

    assign w_rd_word  = r_mem[r_fetch_pc];
    assign w_past_end = ({1'b0, r_fetch_pc} >= r_prog_len);
    assign w_bad_op   = (w_rd_word[27:24] > MAX_OPCODE);
    // Writes are dropped once full so the pointer can never wrap onto entry 0.
    assign w_mem_we   = (r_state == S_LOAD) && le_pm && load_wr && !r_load_full;

    // Program memory is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_load_ptr] <= load_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_LOAD;
            r_instruction <= 28'd0;
            r_instr_valid <= 1'b0;
            r_fetch_pc    <= 5'd0;
            r_load_ptr    <= 5'd0;
            r_prog_len    <= 6'd0;
            r_load_full   <= 1'b0;
            r_halted      <= 1'b0;
        end else if (le_pm && (r_state != S_LOAD)) begin
            // Load request pre-empts everything, including a same-cycle retire.
            r_state       <= S_LOAD;
            r_instr_valid <= 1'b0;
            r_load_ptr    <= 5'd0;
            r_prog_len    <= 6'd0;
            r_load_full   <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (le_pm) begin
                        if (w_mem_we) begin
                            r_load_ptr  <= r_load_ptr + 5'd1;
                            r_prog_len  <= r_prog_len + 6'd1;
                            r_load_full <= (r_prog_len == 6'(DEPTH - 1));
                        end
                    end else begin
                        r_fetch_pc <= 5'd0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_past_end || w_bad_op) begin
                        r_instr_valid <= 1'b0;
                        r_halted      <= 1'b1;
                        r_state       <= S_HALT;
                    end else begin
                        r_instruction <= w_rd_word;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (exec_done) begin
                        r_instr_valid <= 1'b0;
                        r_fetch_pc    <= pc_next;
                        r_state       <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_instr_valid <= 1'b0;
                    r_halted      <= 1'b1;
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign instruction = r_instruction;
    assign instr_valid = r_instr_valid;
    assign fetch_pc    = r_fetch_pc;
    assign prog_len    = r_prog_len;
    assign load_full   = r_load_full;
    assign halted      = r_halted;

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port le_pm, input, 1: program-load mode; 1 = load, 0 = run.
REQ-004 SHALL have port load_wr, input, 1: write strobe for load_instr, sampled only while le_pm=1.
REQ-005 SHALL have port load_instr, input, 28: instruction word {opcode[27:24], op1[23:16], op2[15:8], op3[7:0]}.
REQ-006 SHALL have port exec_done, input, 1: single-cycle pulse from the executor when the issued instruction has retired.
REQ-007 SHALL have port pc_next, input, 5: executor's next PC, sampled with exec_done (PC+1 or jmp target).
REQ-008 SHALL have port instruction, output, 28: registered instruction being issued.
REQ-009 SHALL have port instr_valid, output, 1: instruction is valid and held stable.
REQ-010 SHALL have port fetch_pc, output, 5: address of the current or next instruction.
REQ-011 SHALL have port prog_len, output, 6: number of instructions loaded (0..32).
REQ-012 SHALL have port load_full, output, 1: all 32 program entries are written.
REQ-013 SHALL have port halted, output, 1: execution has stopped.

Function
REQ-014 SHALL contain a 32 x 28-bit program memory; contents are not reset.
REQ-015 SHALL implement the states LOAD, FETCH, ISSUE, HALT.
REQ-016 SHALL enter LOAD from any state in the cycle after le_pm=1 is sampled, clearing load_ptr, prog_len, instr_valid, halted and load_full.
REQ-017 In LOAD, each cycle with load_wr=1 SHALL write mem[load_ptr], then increment load_ptr and prog_len by 1.
REQ-018 When prog_len reaches 32, load_full SHALL go to 1; further load_wr SHALL be dropped with no wrap-around and no overwrite.
REQ-019 On le_pm sampled 0 while in LOAD, SHALL set fetch_pc=0 and go to FETCH.
REQ-020 In FETCH, if fetch_pc >= prog_len, SHALL go to HALT; no instruction is issued.
REQ-021 In FETCH, if mem[fetch_pc] opcode >= 7, SHALL go to HALT; instr_valid is never asserted for that word.
REQ-022 Otherwise FETCH SHALL register mem[fetch_pc] into instruction and go to ISSUE, with instr_valid=1 from the next cycle.
REQ-023 In ISSUE, instruction and instr_valid=1 SHALL stay constant until exec_done=1 is sampled.
REQ-024 On exec_done in ISSUE, SHALL clear instr_valid, load fetch_pc with pc_next and go to FETCH; the next instr_valid rises 2 cycles after exec_done.
REQ-025 exec_done outside ISSUE SHALL be ignored.
REQ-026 If le_pm=1 and exec_done=1 occur in the same cycle, le_pm SHALL win and pc_next SHALL be discarded.
REQ-027 In HALT, SHALL set halted=1 and instr_valid=0, and remain in HALT until le_pm=1 or reset.
REQ-028 A jump (pc_next) to an address >= prog_len SHALL lead to HALT through REQ-020.

Reset
REQ-029 With rst_n=0, SHALL immediately (asynchronously) enter LOAD with instr_valid=0, instruction=0, fetch_pc=0, prog_len=0, load_ptr=0, load_full=0, halted=0.
REQ-030 Reset during ISSUE SHALL drop instr_valid at once; mem contents SHALL be kept.
REQ-031 After reset release with le_pm=0, SHALL go to FETCH, then to HALT, because prog_len=0.

Verification
REQ-032 Load 3 words (0x0010203, 0x1070605, 0x6000000) and drop le_pm -> prog_len=3; instruction=0x0010203 with instr_valid=1 two cycles later.
REQ-033 Pulse exec_done with pc_next=1, then with pc_next=2 -> 0x1070605 issued, then 0x6000000; each instr_valid rises 2 cycles after its exec_done.
REQ-034 pc_next=0 on the jmp retire -> loop restarts at fetch_pc=0; pc_next=5 with prog_len=3 -> halted=1 and instr_valid stays 0.
REQ-035 Load 33 words -> load_full=1 after the 32nd; prog_len=32; mem[0] still holds the 1st word.
REQ-036 Program word with opcode 0xF at address 1 -> after the first retire, halted=1 and 0xF word never appears with instr_valid=1.
REQ-037 rst_n low mid-ISSUE, then le_pm=1 and exec_done=1 in the same cycle -> instr_valid=0 at once, LOAD entered, pc_next ignored.
